quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Quadrature front-end that converts two asynchronous phase inputs (A/B, Gray-coded) into single-cycle `inc`/`dec` step commands. Its outputs drive the inc/dec inputs of the team's up/down step counters. It synchronises and glitch-filters both phases, decodes every legal edge (x4 decoding) into exactly one step pulse, and flags and counts illegal double-edge transitions.

## Interface
- `FILT`, default 3: number of consecutive cycles a synchronised phase must differ from its filtered value before the filtered value updates; legal range 1..15.
- `ERRW`, default 8: width of the saturating error counter.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `a_in`  in  1  phase A, asynchronous to `clk`.
- `b_in`  in  1  phase B, asynchronous to `clk`.
- `en`  in  1  step-output enable, synchronous.
- `inc`  out  1  registered one-cycle pulse: one forward step.
- `dec`  out  1  registered one-cycle pulse: one reverse step.
- `err`  out  1  registered one-cycle pulse: illegal transition seen.
- `dir`  out  1  last decoded direction, 1 = forward, 0 = reverse.
- `err_cnt`  out  ERRW  saturating count of illegal transitions.

## Operation
- Reset value of all state is 0: sync flops, filtered phases `a_f`/`b_f`, filter counters, `inc`, `dec`, `err`, `dir`, and `err_cnt`. The decoder therefore starts in state 00.
- Synchroniser: two flops per phase; only the second-stage outputs `a_s`/`b_s` feed logic.
- Filter, per phase and independent:
  - if `x_s == x_f`, the counter clears;
  - otherwise, if counter == FILT-1, `x_f <= x_s` and the counter clears;
  - otherwise the counter increments.
  - A disagreement shorter than FILT cycles never reaches `x_f`.
- Decoder: compare the previous registered `{a_f,b_f}` with the current value each cycle.
  - Forward sequence is 00→01→11→10→00. A transition along it sets `inc`=1 and `dir`=1.
  - Reverse sequence is 00→10→11→01→00. A transition along it sets `dec`=1 and `dir`=0.
  - Both bits changing in the same cycle (00↔11, 01↔10) sets `err`=1. It produces no `inc`/`dec`, leaves `dir` unchanged, and increments `err_cnt`, saturating at 2^ERRW-1 (no wrap).
  - No change: `inc`, `dec`, and `err` are all 0.
- `inc` and `dec` are never high in the same cycle. `err` is exclusive with both.
- `en`=0:
  - sync, filter, and decoder state keep tracking;
  - `inc`, `dec`, and `err` are forced to 0;
  - `dir` and `err_cnt` hold.
  - Re-enabling does not replay edges missed while disabled.
- Simultaneous filter updates on A and B in the same cycle count as an illegal transition, even if the raw inputs changed on different cycles.
- `rst` asserted at any time clears everything immediately, including any in-progress filter count. After release, the current input levels are treated as new edges relative to the reset state 00. For example, inputs held at 11 through reset produce one `err` once both filters update together.

## Timing
- Latency: `inc`/`dec`/`err` goes high for exactly one cycle after FILT+3 rising edges, counting from the first edge that samples the new input level. This is 6 edges at FILT=3.
- Breakdown of that latency:
  - edges 1–2: synchroniser;
  - edges 3..FILT+2: filter, with `x_f` updating at edge FILT+2;
  - edge FILT+3: output register.
- Maximum step rate: one legal edge per phase per FILT+1 cycles. Faster inputs are filtered or reported as `err`.
- `dir` and `err_cnt` update on the same edge as their corresponding pulse.
- `rst` deassertion takes effect on the next rising edge. There is no synchronous-release requirement inside the block.

## Test plan
- Reset check: hold `rst` with A=B=0, then release and idle 20 cycles. Required: `inc`=`dec`=`err`=0, `dir`=0, `err_cnt`=0 throughout.
- Forward rotation (FILT=3, `en`=1): drive AB 00→01→11→10→00, each level held 10 cycles. Required: exactly 4 `inc` pulses, each 6 edges after its input change; no `dec`; `dir`=1 after the first pulse.
- Reverse rotation: drive AB 00→10→11→01→00. Required: exactly 4 `dec` pulses and `dir`=0.
- Glitch rejection (FILT=3): pulse A high for 2 cycles, then back low. Required: no `inc`/`dec`/`err`; `a_f` stays 0.
- Illegal transition and saturation (ERRW=2): from 00, drive AB to 11 in the same cycle, then back to 00; repeat 5 times. Required: 10 `err` pulses, no `inc`/`dec`, and `err_cnt` reading 1, 2, 3, 3, … (saturates at 3).
- Disable and mid-operation reset: with `en`=0, drive 00→01, then set `en`=1 and drive 01→11. Required: no pulse for the first edge and one `inc` for the second. Then assert `rst` 2 cycles after an A change (mid-filter). Required: all outputs 0 immediately; after release, inputs at 11 yield one `err` and `err_cnt`=1.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front-end: two-flop synchronisers, per-phase glitch filters and an
// x4 Gray-code decoder producing registered inc/dec/err pulses plus a saturating error count.
module quad_step_decoder #(
  parameter int FILT = 3,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_in,
  input  logic            b_in,
  input  logic            en,
  output logic            inc,
  output logic            dec,
  output logic            err,
  output logic            dir,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [3:0] FILT_LAST = 4'(FILT - 1);

  logic       a_meta_r, b_meta_r;
  logic       a_s, b_s;
  logic       a_f, b_f;
  logic [3:0] a_cnt_r, b_cnt_r;
  logic [1:0] ab_prev_r;

  logic [4:0] a_filt_nxt_s, b_filt_nxt_s;
  logic [1:0] step_s;
  logic       fwd_s, rev_s, ill_s, cnt_sat_s;

  // One filter step: returns {next filtered value, next disagreement count}.
  function automatic logic [4:0] filt_step(input logic s, input logic f, input logic [3:0] cnt);
    logic [4:0] r;
    if (s == f) begin
      r = {f, 4'd0};
    end else if (cnt == FILT_LAST) begin
      r = {s, 4'd0};
    end else begin
      r = {f, cnt + 4'd1};
    end
    return r;
  endfunction

  // Position of an AB pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      2'b10:   p = 2'd3;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  // Two-stage synchronisers for both phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_meta_r <= 1'b0;
      b_meta_r <= 1'b0;
      a_s      <= 1'b0;
      b_s      <= 1'b0;
    end else begin
      a_meta_r <= a_in;
      b_meta_r <= b_in;
      a_s      <= a_meta_r;
      b_s      <= b_meta_r;
    end
  end

  // Filter next-state for both phases.
  always_comb begin
    a_filt_nxt_s = filt_step(a_s, a_f, a_cnt_r);
    b_filt_nxt_s = filt_step(b_s, b_f, b_cnt_r);
  end

  // Filtered phases, their counters and the previous filtered pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_f       <= 1'b0;
      b_f       <= 1'b0;
      a_cnt_r   <= 4'd0;
      b_cnt_r   <= 4'd0;
      ab_prev_r <= 2'b00;
    end else begin
      a_f       <= a_filt_nxt_s[4];
      a_cnt_r   <= a_filt_nxt_s[3:0];
      b_f       <= b_filt_nxt_s[4];
      b_cnt_r   <= b_filt_nxt_s[3:0];
      ab_prev_r <= {a_f, b_f};
    end
  end

  // Classify the move between previous and current filtered pair; a distance of two is illegal.
  always_comb begin
    step_s    = gray_pos({a_f, b_f}) - gray_pos(ab_prev_r);
    fwd_s     = 1'b0;
    rev_s     = 1'b0;
    ill_s     = 1'b0;
    cnt_sat_s = (err_cnt == {ERRW{1'b1}});
    case (step_s)
      2'd1:    fwd_s = 1'b1;
      2'd3:    rev_s = 1'b1;
      2'd2:    ill_s = 1'b1;
      default: begin
        fwd_s = 1'b0;
        rev_s = 1'b0;
        ill_s = 1'b0;
      end
    endcase
  end

  // Registered pulses, direction and saturating error count, all gated by en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc     <= 1'b0;
      dec     <= 1'b0;
      err     <= 1'b0;
      dir     <= 1'b0;
      err_cnt <= {ERRW{1'b0}};
    end else begin
      inc <= en & fwd_s;
      dec <= en & rev_s;
      err <= en & ill_s;
      if (en && fwd_s) begin
        dir <= 1'b1;
      end else if (en && rev_s) begin
        dir <= 1'b0;
      end else begin
        dir <= dir;
      end
      if (en && ill_s && !cnt_sat_s) begin
        err_cnt <= err_cnt + ERRW'(1);
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a windowed reference model predicts each pulse
// (kind, cycle, dir, err_cnt); a negedge monitor pops and compares.
module tb_quad_step_decoder;

  localparam int FILT = 3;
  localparam int ERRW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            a_in = 1'b0;
  logic            b_in = 1'b0;
  logic            en = 1'b1;
  logic            inc, dec, err, dir;
  logic [ERRW-1:0] err_cnt;

  quad_step_decoder #(.FILT(FILT), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en),
    .inc(inc), .dec(dec), .err(err), .dir(dir), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      kind;  // {inc,dec,err}
    logic            dir;
    logic [ERRW-1:0] cnt;
    int              cyc;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              n_inc = 0, n_dec = 0, n_err = 0;
  bit              qa[$], qb[$];
  logic            fa = 1'b0, fb = 1'b0, fpa = 1'b0, fpb = 1'b0;
  logic            m_dir = 1'b0;
  logic [ERRW-1:0] m_cnt = '0;

  function automatic int gpos(input logic a, input logic b);
    if (a) return b ? 2 : 3;
    return b ? 1 : 0;
  endfunction

  // True when the last FILT synchronised samples all disagree with the filtered level f.
  function automatic bit filt_hit(input bit q[$], input logic f);
    int n = q.size();
    if (n < FILT + 1) return 1'b0;
    for (int j = 0; j < FILT; j++) begin
      if (q[n-2-j] == f) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: sample history per phase since reset; the two leading zeros stand for
  // the cleared synchroniser stages.
  initial begin
    int   d;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        qa = {}; qb = {};
        qa.push_back(1'b0); qa.push_back(1'b0);
        qb.push_back(1'b0); qb.push_back(1'b0);
        fa = 1'b0; fb = 1'b0; fpa = 1'b0; fpb = 1'b0;
        m_dir = 1'b0; m_cnt = '0;
      end else begin
        d = (gpos(fa, fb) - gpos(fpa, fpb) + 4) % 4;
        if (en && d != 0) begin
          if (d == 1) begin
            m_dir = 1'b1; e.kind = 3'b100;
          end else if (d == 3) begin
            m_dir = 1'b0; e.kind = 3'b010;
          end else begin
            if (m_cnt != {ERRW{1'b1}}) m_cnt = m_cnt + 1'b1;
            e.kind = 3'b001;
          end
          e.dir = m_dir; e.cnt = m_cnt; e.cyc = cyc;
          sbq.push_back(e);
        end
        fpa = fa; fpb = fb;
        if (filt_hit(qa, fa)) fa = ~fa;
        if (filt_hit(qb, fb)) fb = ~fb;
        qa.push_back(a_in); qb.push_back(b_in);
        if (qa.size() > 40) begin
          void'(qa.pop_front()); void'(qb.pop_front());
        end
      end
    end
  end

  // Monitor: pops an expectation for every pulse, flags missing/unexpected pulses and state drift.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inc | dec | err) begin
          n_inc += int'(inc); n_dec += int'(dec); n_err += int'(err);
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: cyc %0d got {inc,dec,err}=%b expected none", cyc, {inc, dec, err});
          end else begin
            e = sbq.pop_front();
            if ({inc, dec, err} !== e.kind || dir !== e.dir || err_cnt !== e.cnt || cyc != e.cyc) begin
              failures++;
              $display("FAIL pulse: got kind=%b dir=%b cnt=%0d cyc=%0d expected kind=%b dir=%b cnt=%0d cyc=%0d",
                       {inc, dec, err}, dir, err_cnt, cyc, e.kind, e.dir, e.cnt, e.cyc);
            end
          end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          checks++; failures++;
          $display("FAIL missing_pulse: got none at cyc %0d expected kind=%b at cyc %0d", cyc, e.kind, e.cyc);
        end
        checks++;
        if (dir !== m_dir || err_cnt !== m_cnt) begin
          failures++;
          $display("FAIL state: got dir=%b err_cnt=%0d expected dir=%b err_cnt=%0d", dir, err_cnt, m_dir, m_cnt);
        end
      end
    end
  end

  task automatic drive(input logic a, input logic b, input int hold);
    @(negedge clk); #2;
    a_in = a; b_in = b;
    repeat (hold) @(posedge clk);
  endtask

  initial begin
    int i0, d0, e0, fl;
    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("reset_dir", int'(dir), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);

    // Forward rotation
    i0 = n_inc; d0 = n_dec;
    drive(1'b0, 1'b1, 10); drive(1'b1, 1'b1, 10); drive(1'b1, 1'b0, 10); drive(1'b0, 1'b0, 10);
    chk("fwd_inc_count", n_inc - i0, 4);
    chk("fwd_dec_count", n_dec - d0, 0);
    chk("fwd_dir", int'(dir), 1);

    // Reverse rotation
    i0 = n_inc; d0 = n_dec;
    drive(1'b1, 1'b0, 10); drive(1'b1, 1'b1, 10); drive(1'b0, 1'b1, 10); drive(1'b0, 1'b0, 10);
    chk("rev_dec_count", n_dec - d0, 4);
    chk("rev_inc_count", n_inc - i0, 0);
    chk("rev_dir", int'(dir), 0);

    // Glitch rejection
    i0 = n_inc; d0 = n_dec; e0 = n_err;
    drive(1'b1, 1'b0, 2); drive(1'b0, 1'b0, 12);
    chk("glitch_pulses", (n_inc - i0) + (n_dec - d0) + (n_err - e0), 0);

    // Illegal transitions and saturation
    i0 = n_inc; d0 = n_dec; e0 = n_err;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 10); drive(1'b0, 1'b0, 10);
    end
    chk("ill_err_count", n_err - e0, 10);
    chk("ill_step_count", (n_inc - i0) + (n_dec - d0), 0);
    chk("ill_err_cnt_sat", int'(err_cnt), 3);

    // Disabled edge, then enabled edge
    i0 = n_inc;
    @(negedge clk); #2 en = 1'b0;
    drive(1'b0, 1'b1, 10);
    @(negedge clk); #2 en = 1'b1;
    chk("dis_no_pulse", n_inc - i0, 0);
    drive(1'b1, 1'b1, 10);
    chk("en_one_inc", n_inc - i0, 1);

    // Mid-filter reset, inputs held at 11 through release
    e0 = n_err;
    drive(1'b0, 1'b1, 2);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_imm_pulses", int'({inc, dec, err}), 0);
    chk("rst_imm_dir", int'(dir), 0);
    chk("rst_imm_err_cnt", int'(err_cnt), 0);
    a_in = 1'b1; b_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    repeat (12) @(posedge clk);
    chk("post_rst_err", n_err - e0, 1);
    chk("post_rst_err_cnt", int'(err_cnt), 1);

    // Randomised walk including glitches, illegal moves and disabled stretches
    for (int k = 0; k < 150; k++) begin
      @(negedge clk); #2 en = ($urandom_range(0, 9) != 0);
      fl = $urandom_range(1, 3);
      drive(a_in ^ fl[0], b_in ^ fl[1], $urandom_range(1, 12));
    end
    @(negedge clk); #2 en = 1'b1;
    repeat (20) @(posedge clk);
    chk("drain_queue", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
